// File: rtl/unidade_load_store_pkg.sv
// rtl/unidade_load_store_pkg.sv - shared state and access-size encodings for the load/store unit
package unidade_load_store_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LEITURA = 2'd1,
    ESPERA  = 2'd2,
    ESCRITA = 2'd3
  } estado_t;

  typedef enum logic [1:0] {
    BYTE   = 2'b00,
    HALF   = 2'b01,
    WORD   = 2'b10,
    ILEGAL = 2'b11
  } tamanho_t;

  // Misaligned halves/words and the reserved size code never touch memory.
  function automatic logic desalinhado(input logic [1:0] size, input logic [1:0] offset);
    logic r;
    case (size)
      BYTE:    r = 1'b0;
      HALF:    r = offset[0];
      WORD:    r = (offset != 2'b00);
      default: r = 1'b1;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/unidade_load_store_if.sv
// rtl/unidade_load_store_if.sv - two-port data memory bus between the load/store unit and memory
interface unidade_load_store_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 16
) ();
  logic                  Mem_Read;
  logic [ADDR_WIDTH-1:0] Endereco_leitura;
  logic [DATA_WIDTH-1:0] Read_Data;
  logic                  Mem_Write;
  logic [ADDR_WIDTH-1:0] Endereco_escrita;
  logic [DATA_WIDTH-1:0] Write_Data;

  modport master (
    output Mem_Read, Endereco_leitura, Mem_Write, Endereco_escrita, Write_Data,
    input  Read_Data
  );

  modport slave (
    input  Mem_Read, Endereco_leitura, Mem_Write, Endereco_escrita, Write_Data,
    output Read_Data
  );
endinterface

// File: rtl/unidade_load_store_alinhador_bytes.sv
// rtl/unidade_load_store_alinhador_bytes.sv - big-endian lane extract/extend for loads, lane merge for stores
module alinhador_bytes
  import unidade_load_store_pkg::*;
(
  input  logic [1:0]  offset,
  input  tamanho_t    size,
  input  logic        unsigned_load,
  input  logic [31:0] word_in,
  input  logic [15:0] store_lane,
  output logic [31:0] load_ext,
  output logic [31:0] merged
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = word_in[7:0];
    case (offset)
      2'd0:    byte_sel = word_in[31:24];
      2'd1:    byte_sel = word_in[23:16];
      2'd2:    byte_sel = word_in[15:8];
      default: byte_sel = word_in[7:0];
    endcase
    half_sel = offset[1] ? word_in[15:0] : word_in[31:16];
  end

  always_comb begin
    load_ext = word_in;
    merged   = word_in;
    case (size)
      BYTE: begin
        load_ext = {{24{~unsigned_load & byte_sel[7]}}, byte_sel};
        case (offset)
          2'd0:    merged[31:24] = store_lane[7:0];
          2'd1:    merged[23:16] = store_lane[7:0];
          2'd2:    merged[15:8]  = store_lane[7:0];
          default: merged[7:0]   = store_lane[7:0];
        endcase
      end
      HALF: begin
        load_ext = {{16{~unsigned_load & half_sel[15]}}, half_sel};
        if (offset[1]) merged[15:0]  = store_lane;
        else           merged[31:16] = store_lane;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/unidade_load_store.sv
// rtl/unidade_load_store.sv - single-outstanding load/store initiator with read-modify-write sub-word stores
module unidade_load_store
  import unidade_load_store_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 16
) (
  input  logic                  Clock,
  input  logic                  Reset_n,
  input  logic                  Req_valid,
  output logic                  Req_ready,
  input  logic                  Is_Store,
  input  logic [1:0]            Size,
  input  logic                  Unsigned_Load,
  input  logic [ADDR_WIDTH+1:0] Endereco,
  input  logic [DATA_WIDTH-1:0] Store_Data,
  output logic [DATA_WIDTH-1:0] Load_Data,
  output logic                  Done,
  output logic                  Erro_Alinhamento,
  unidade_load_store_if.master  mem
);

  estado_t               state_q, state_d;
  logic                  is_store_q, is_store_d;
  tamanho_t              size_q, size_d;
  logic                  unsigned_q, unsigned_d;
  logic [1:0]            offset_q, offset_d;
  logic [15:0]           store_lane_q, store_lane_d;
  logic [DATA_WIDTH-1:0] load_data_q, load_data_d;
  logic                  done_q, done_d;
  logic                  erro_q, erro_d;
  logic                  err_pend_q, err_pend_d;
  logic                  mem_read_q, mem_read_d;
  logic                  mem_write_q, mem_write_d;
  logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
  logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_WIDTH-1:0] write_data_q, write_data_d;

  logic [DATA_WIDTH-1:0] load_ext;
  logic [DATA_WIDTH-1:0] merged;

  alinhador_bytes u_alinhador (
    .offset        (offset_q),
    .size          (size_q),
    .unsigned_load (unsigned_q),
    .word_in       (mem.Read_Data),
    .store_lane    (store_lane_q),
    .load_ext      (load_ext),
    .merged        (merged)
  );

  always_comb begin
    state_d      = state_q;
    is_store_d   = is_store_q;
    size_d       = size_q;
    unsigned_d   = unsigned_q;
    offset_d     = offset_q;
    store_lane_d = store_lane_q;
    load_data_d  = load_data_q;
    rd_addr_d    = rd_addr_q;
    wr_addr_d    = wr_addr_q;
    write_data_d = write_data_q;
    done_d       = 1'b0;
    erro_d       = 1'b0;
    err_pend_d   = 1'b0;
    mem_read_d   = 1'b0;
    mem_write_d  = 1'b0;

    // A rejected request reports one cycle after acceptance, like a word store.
    if (err_pend_q) begin
      done_d = 1'b1;
      erro_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (Req_valid) begin
          if (desalinhado(Size, Endereco[1:0])) begin
            err_pend_d = 1'b1;
          end else begin
            is_store_d   = Is_Store;
            size_d       = tamanho_t'(Size);
            unsigned_d   = Unsigned_Load;
            offset_d     = Endereco[1:0];
            store_lane_d = Store_Data[15:0];
            rd_addr_d    = Endereco[ADDR_WIDTH+1:2];
            wr_addr_d    = Endereco[ADDR_WIDTH+1:2];
            if (Is_Store && tamanho_t'(Size) == WORD) begin
              write_data_d = Store_Data;
              mem_write_d  = 1'b1;
              state_d      = ESCRITA;
            end else begin
              mem_read_d = 1'b1;
              state_d    = LEITURA;
            end
          end
        end
      end
      LEITURA: state_d = ESPERA;
      ESPERA: begin
        if (is_store_q) begin
          write_data_d = merged;
          mem_write_d  = 1'b1;
          state_d      = ESCRITA;
        end else begin
          load_data_d = load_ext;
          done_d      = 1'b1;
          state_d     = IDLE;
        end
      end
      ESCRITA: begin
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q      <= IDLE;
      is_store_q   <= 1'b0;
      size_q       <= BYTE;
      unsigned_q   <= 1'b0;
      offset_q     <= 2'b00;
      store_lane_q <= '0;
      load_data_q  <= '0;
      done_q       <= 1'b0;
      erro_q       <= 1'b0;
      err_pend_q   <= 1'b0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      rd_addr_q    <= '0;
      wr_addr_q    <= '0;
      write_data_q <= '0;
    end else begin
      state_q      <= state_d;
      is_store_q   <= is_store_d;
      size_q       <= size_d;
      unsigned_q   <= unsigned_d;
      offset_q     <= offset_d;
      store_lane_q <= store_lane_d;
      load_data_q  <= load_data_d;
      done_q       <= done_d;
      erro_q       <= erro_d;
      err_pend_q   <= err_pend_d;
      mem_read_q   <= mem_read_d;
      mem_write_q  <= mem_write_d;
      rd_addr_q    <= rd_addr_d;
      wr_addr_q    <= wr_addr_d;
      write_data_q <= write_data_d;
    end
  end

  assign Req_ready            = (state_q == IDLE);
  assign Load_Data            = load_data_q;
  assign Done                 = done_q;
  assign Erro_Alinhamento     = erro_q;
  assign mem.Mem_Read         = mem_read_q;
  assign mem.Mem_Write        = mem_write_q;
  assign mem.Endereco_leitura = rd_addr_q;
  assign mem.Endereco_escrita = wr_addr_q;
  assign mem.Write_Data       = write_data_q;

endmodule

// File: tb/tb_unidade_load_store.sv
// tb/tb_unidade_load_store.sv - directed self-checking bench for unidade_load_store with a two-port memory model
module tb_unidade_load_store;

  logic        Clock;
  logic        Reset_n;
  logic        Req_valid;
  logic        Req_ready;
  logic        Is_Store;
  logic [1:0]  Size;
  logic        Unsigned_Load;
  logic [17:0] Endereco;
  logic [31:0] Store_Data;
  logic [31:0] Load_Data;
  logic        Done;
  logic        Erro_Alinhamento;

  int n_cmp = 0;
  int n_err = 0;

  unidade_load_store_if #(.DATA_WIDTH(32), .ADDR_WIDTH(16)) mif ();

  unidade_load_store #(.DATA_WIDTH(32), .ADDR_WIDTH(16)) dut (
    .Clock            (Clock),
    .Reset_n          (Reset_n),
    .Req_valid        (Req_valid),
    .Req_ready        (Req_ready),
    .Is_Store         (Is_Store),
    .Size             (Size),
    .Unsigned_Load    (Unsigned_Load),
    .Endereco         (Endereco),
    .Store_Data       (Store_Data),
    .Load_Data        (Load_Data),
    .Done             (Done),
    .Erro_Alinhamento (Erro_Alinhamento),
    .mem              (mif)
  );

  logic [31:0] mem_arr [0:63];

  always @(posedge Clock) begin
    if (mif.Mem_Read)  mif.Read_Data <= mem_arr[mif.Endereco_leitura[5:0]];
    if (mif.Mem_Write) mem_arr[mif.Endereco_escrita[5:0]] <= mif.Write_Data;
  end

  initial begin
    Clock = 1'b0;
    forever #5 Clock = ~Clock;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Called just after a falling edge; request is accepted at the next rising edge (E0).
  // lat = index j of the cycle Ej..Ej+1 in which Done is seen.
  task automatic run_req(input logic st, input logic [1:0] sz, input logic uns,
                         input logic [17:0] addr, input logic [31:0] data,
                         output int lat, output int nrd, output int nwr,
                         output logic [15:0] waddr, output logic erro);
    chk("ready_before_accept", {31'd0, Req_ready}, 32'd1);
    Req_valid = 1'b1; Is_Store = st; Size = sz; Unsigned_Load = uns;
    Endereco = addr; Store_Data = data;
    @(posedge Clock);
    #1;
    Req_valid = 1'b0; Is_Store = ~st; Endereco = 18'h3FFFF; Store_Data = 32'h0;
    lat = -1; nrd = 0; nwr = 0; waddr = '0; erro = 1'b0;
    for (int j = 0; j < 12; j++) begin
      @(negedge Clock);
      if (mif.Mem_Read) nrd++;
      if (mif.Mem_Write) begin
        nwr++;
        waddr = mif.Endereco_escrita;
      end
      if (Done) begin
        lat  = j;
        erro = Erro_Alinhamento;
        break;
      end
    end
  endtask

  int          lat, nrd, nwr, ndone;
  logic [15:0] waddr;
  logic        erro;

  initial begin
    Reset_n = 1'b0; Req_valid = 1'b0; Is_Store = 1'b0; Size = 2'b00;
    Unsigned_Load = 1'b0; Endereco = '0; Store_Data = '0;
    repeat (2) @(negedge Clock);
    Reset_n = 1'b1;
    @(negedge Clock);
    chk("rst_ready", {31'd0, Req_ready}, 32'd1);
    chk("rst_load_data", Load_Data, 32'd0);
    chk("rst_flags", {28'd0, Done, Erro_Alinhamento, mif.Mem_Read, mif.Mem_Write}, 32'd0);
    chk("rst_addrs", {mif.Endereco_leitura, mif.Endereco_escrita}, 32'd0);
    chk("rst_wdata", mif.Write_Data, 32'd0);

    // Word store then load
    run_req(1, 2'b10, 0, 18'h0010, 32'hDEADBEEF, lat, nrd, nwr, waddr, erro);
    chk("sw_lat", lat, 32'd1);
    chk("sw_nwr_nrd", {nwr[15:0], nrd[15:0]}, {16'd1, 16'd0});
    chk("sw_waddr", {16'd0, waddr}, 32'd4);
    chk("sw_erro", {31'd0, erro}, 32'd0);
    chk("sw_mem", mem_arr[4], 32'hDEADBEEF);
    run_req(0, 2'b10, 0, 18'h0010, 32'h0, lat, nrd, nwr, waddr, erro);
    chk("lw_lat", lat, 32'd2);
    chk("lw_nrd", {nwr[15:0], nrd[15:0]}, {16'd0, 16'd1});
    chk("lw_data", Load_Data, 32'hDEADBEEF);

    // Sign / zero extension
    run_req(1, 2'b10, 0, 18'h0010, 32'h80FF7F01, lat, nrd, nwr, waddr, erro);
    run_req(0, 2'b00, 0, 18'h0011, 32'h0, lat, nrd, nwr, waddr, erro);
    chk("lb_data", Load_Data, 32'hFFFFFFFF);
    chk("lb_lat", lat, 32'd2);
    run_req(0, 2'b00, 1, 18'h0011, 32'h0, lat, nrd, nwr, waddr, erro);
    chk("lbu_data", Load_Data, 32'h000000FF);
    run_req(0, 2'b01, 0, 18'h0012, 32'h0, lat, nrd, nwr, waddr, erro);
    chk("lh_hi_off2", Load_Data, 32'h00007F01);
    run_req(0, 2'b01, 0, 18'h0010, 32'h0, lat, nrd, nwr, waddr, erro);
    chk("lh_off0", Load_Data, 32'hFFFF80FF);

    // Read-modify-write
    run_req(1, 2'b10, 0, 18'h0010, 32'h11223344, lat, nrd, nwr, waddr, erro);
    run_req(1, 2'b00, 0, 18'h0012, 32'hFFFFFFAA, lat, nrd, nwr, waddr, erro);
    chk("sb_lat", lat, 32'd3);
    chk("sb_nwr_nrd", {nwr[15:0], nrd[15:0]}, {16'd1, 16'd1});
    chk("sb_mem", mem_arr[4], 32'h1122AA44);
    run_req(1, 2'b01, 0, 18'h0010, 32'h0000BEEF, lat, nrd, nwr, waddr, erro);
    chk("sh_mem", mem_arr[4], 32'hBEEFAA44);
    chk("sh_lat", lat, 32'd3);

    // Misaligned and illegal requests
    run_req(0, 2'b10, 0, 18'h0012, 32'h0, lat, nrd, nwr, waddr, erro);
    chk("lw_mis_lat", lat, 32'd1);
    chk("lw_mis_erro", {31'd0, erro}, 32'd1);
    chk("lw_mis_noacc", {nwr[15:0], nrd[15:0]}, 32'd0);
    chk("lw_mis_ld", Load_Data, 32'hFFFF80FF);
    run_req(1, 2'b01, 0, 18'h0013, 32'h00001234, lat, nrd, nwr, waddr, erro);
    chk("sh_mis_lat_erro", {lat[15:0], 15'd0, erro}, {16'd1, 16'd1});
    chk("sh_mis_noacc", {nwr[15:0], nrd[15:0]}, 32'd0);
    chk("sh_mis_mem", mem_arr[4], 32'hBEEFAA44);
    run_req(0, 2'b11, 0, 18'h0010, 32'h0, lat, nrd, nwr, waddr, erro);
    chk("ill_lat_erro", {lat[15:0], 15'd0, erro}, {16'd1, 16'd1});
    chk("ill_noacc", {nwr[15:0], nrd[15:0]}, 32'd0);
    chk("ill_ld", Load_Data, 32'hFFFF80FF);

    // Back-to-back: each request issued in the previous Done cycle
    run_req(0, 2'b10, 0, 18'h0010, 32'h0, lat, nrd, nwr, waddr, erro);
    chk("b2b_lw0", Load_Data, 32'hBEEFAA44);
    chk("b2b_lw0_erro", {31'd0, erro}, 32'd0);
    run_req(1, 2'b10, 0, 18'h0020, 32'h12345678, lat, nrd, nwr, waddr, erro);
    chk("b2b_sw_lat", lat, 32'd1);
    chk("b2b_sw_waddr", {16'd0, waddr}, 32'd8);
    run_req(0, 2'b10, 0, 18'h0020, 32'h0, lat, nrd, nwr, waddr, erro);
    chk("b2b_lw_lat", lat, 32'd2);
    chk("b2b_lw_data", Load_Data, 32'h12345678);

    // Reset while an SB sits in ESPERA
    Req_valid = 1'b1; Is_Store = 1'b1; Size = 2'b00; Unsigned_Load = 1'b0;
    Endereco = 18'h0021; Store_Data = 32'h00000055;
    @(posedge Clock);
    #1 Req_valid = 1'b0;
    @(posedge Clock);
    #2 Reset_n = 1'b0;
    #1;
    chk("amid_ready", {31'd0, Req_ready}, 32'd1);
    chk("amid_ld", Load_Data, 32'd0);
    chk("amid_flags", {28'd0, Done, Erro_Alinhamento, mif.Mem_Read, mif.Mem_Write}, 32'd0);
    chk("amid_addrs", {mif.Endereco_leitura, mif.Endereco_escrita}, 32'd0);
    chk("amid_wdata", mif.Write_Data, 32'd0);
    repeat (2) @(negedge Clock);
    Reset_n = 1'b1;
    ndone = 0; nwr = 0;
    for (int j = 0; j < 5; j++) begin
      @(negedge Clock);
      if (Done) ndone++;
      if (mif.Mem_Write) nwr++;
    end
    chk("amid_no_done_wr", {ndone[15:0], nwr[15:0]}, 32'd0);
    chk("amid_mem", mem_arr[8], 32'h12345678);
    run_req(0, 2'b10, 0, 18'h0020, 32'h0, lat, nrd, nwr, waddr, erro);
    chk("post_rst_lw", Load_Data, 32'h12345678);
    chk("post_rst_lat", lat, 32'd2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/unidade_load_store.md
# unidade_load_store

Initiator side of the data-memory port: accepts one load/store request at a time from the CPU datapath and drives the word-wide, two-port data memory through its read port (`Mem_Read`, `Endereco_leitura`, `Read_Data`) and write port (`Mem_Write`, `Endereco_escrita`, `Write_Data`). Byte and halfword loads use lane extraction plus sign or zero extension. The memory has no byte enables, so byte and halfword stores are done as read-modify-write. The memory's `read_Clock` and `write_Clock` are both tied to this block's `Clock`.

## Interface
- `DATA_WIDTH`, default 32: word width. Only 32 is supported.
- `ADDR_WIDTH`, default 16: memory word-address width. The byte address is `ADDR_WIDTH+2` bits.
- `Clock`  in  1  single clock; all logic is on the rising edge.
- `Reset_n`  in  1  asynchronous, active-low reset.
- `Req_valid`  in  1  request present.
- `Req_ready`  out  1  block idle and able to accept; equal to `state==IDLE`.
- `Is_Store`  in  1  1 = store, 0 = load.
- `Size`  in  2  00 = byte, 01 = half, 10 = word, 11 = illegal.
- `Unsigned_Load`  in  1  zero-extend when 1 (lbu/lhu); ignored for stores and for word loads.
- `Endereco`  in  ADDR_WIDTH+2  byte address.
- `Store_Data`  in  32  store source; byte in [7:0], half in [15:0].
- `Load_Data`  out  32  extended load result; holds until the next completed load.
- `Done`  out  1  one-cycle completion pulse.
- `Erro_Alinhamento`  out  1  one-cycle pulse, coincident with `Done`, on a misaligned or illegal request.
- `Mem_Read`  out  1  memory read enable.
- `Endereco_leitura`  out  ADDR_WIDTH  read word address.
- `Read_Data`  in  32  registered memory read data.
- `Mem_Write`  out  1  memory write enable.
- `Endereco_escrita`  out  ADDR_WIDTH  write word address.
- `Write_Data`  out  32  write data.

## Operation
- Handshake: a request is accepted on a rising edge where `Req_valid && Req_ready`. Request fields are registered at acceptance and may change afterwards.
- Word address = `Endereco[ADDR_WIDTH+1:2]`. Byte offset = `Endereco[1:0]`.
- Byte order is big-endian:
  - offset 0 → bits [31:24], offset 3 → bits [7:0].
  - half offset 0 → [31:16], half offset 2 → [15:0].
- Error conditions (checked at acceptance):
  - half with `Endereco[0]=1`;
  - word with `Endereco[1:0]!=0`;
  - `Size=11`.
  - Action: no memory access, state stays IDLE, `Done` and `Erro_Alinhamento` pulse in the next cycle, `Load_Data` unchanged.
- States: IDLE, LEITURA, ESPERA, ESCRITA.
- IDLE →
  - LEITURA on an accepted load or sub-word store.
  - ESCRITA on an accepted word store.
- LEITURA → ESPERA unconditionally.
- ESPERA:
  - load: capture `Read_Data`, extend into `Load_Data`, pulse `Done`, go to IDLE.
  - sub-word store: merge the store lane into the captured word, go to ESCRITA.
- ESCRITA → IDLE, with `Done` pulsing in the following cycle.
- Outputs are all registered.
  - `Mem_Read=1` only while in LEITURA.
  - `Mem_Write=1` only while in ESCRITA.
  - Addresses and `Write_Data` are stable for the whole request.
- Reset values: `Req_ready=1`, and all other outputs 0 (`Load_Data`, `Done`, `Erro_Alinhamento`, `Mem_Read`, `Mem_Write`, `Endereco_leitura`, `Endereco_escrita`, `Write_Data`).
- Reset mid-operation: return immediately to IDLE and drop all outputs to reset values. No `Done` is produced for the aborted request. An RMW aborted before its ESCRITA edge leaves memory unchanged.

## Timing
- Acceptance is at edge E0.
- Word store:
  - `Mem_Write` high during E0–E1; memory writes at E1.
  - `Done` high during E1–E2.
  - Latency 1.
- Load:
  - `Mem_Read` high during E0–E1; memory registers the word at E1.
  - Block captures it at E2; `Done` and the new `Load_Data` are valid during E2–E3.
  - Latency 2.
- Sub-word store:
  - read as for a load; merge at E2;
  - `Mem_Write` high during E2–E3; write occurs at E3;
  - `Done` high during E3–E4.
  - Latency 3.
- Misaligned or illegal request: latency 1.
- `Req_ready` is high in the same cycle as `Done`, so a new request may be accepted at the edge that ends the `Done` cycle (back-to-back).
- Read-after-store to the same word sees the new data: the store's write edge always precedes the next request's read-sample edge.
- `Req_valid` while `Req_ready=0` is ignored and is not queued.

## Structure
- Shared package: state encoding (IDLE, LEITURA, ESPERA, ESCRITA) and `Size` codes (BYTE, HALF, WORD).
- Sub-module `alinhador_bytes` (combinational), containing:
  - lane extraction and sign/zero extension for loads;
  - lane merge for stores, given offset, size and data.
- The top level holds the FSM, the request registers and the memory-side registers.

## Test plan
- Word store then load:
  - stimulus: SW `0xDEADBEEF` @ `0x0010`, then LW @ `0x0010`.
  - required: `Mem_Write` for 1 cycle at word 4, `Done` 1 cycle later; LW `Done` 2 cycles after acceptance with `Load_Data=0xDEADBEEF`.
- Sign extension:
  - setup: memory word 4 = `0x80FF7F01`.
  - LB @ `0x0011` → `0xFFFFFFFF`.
  - LBU @ `0x0011` → `0x000000FF`.
  - LH @ `0x0012` → `0x00007F01`.
  - LH @ `0x0010` → `0xFFFF80FF`.
- Read-modify-write:
  - setup: word 4 = `0x11223344`.
  - SB `0xAA` @ `0x0012` → memory `0x1122AA44`, `Done` 3 cycles after acceptance.
  - SH `0xBEEF` @ `0x0010` → memory `0xBEEFAA44`.
- Misalignment and illegal size:
  - stimulus: LW @ `0x0012`; SH @ `0x0013`; `Size=11`.
  - required: no `Mem_Read`/`Mem_Write` pulses; `Done` and `Erro_Alinhamento` 1 cycle after acceptance; `Load_Data` unchanged.
- Back-to-back:
  - stimulus: SW `0x12345678` @ `0x0020` accepted in the `Done` cycle of a previous load, then LW @ `0x0020` accepted in the SW's `Done` cycle.
  - required: LW returns `0x12345678`; no idle gaps.
- Reset mid-RMW:
  - stimulus: assert `Reset_n=0` while in ESPERA of an SB.
  - required: outputs go to reset values asynchronously, no `Done`, memory word unchanged, `Req_ready=1` after release.
